// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants and types for the pipeline skid stage.
// Default payload widths and the occupancy count type live here.
package pipe_pkg;

    localparam int DEF_DATA_W = 96;
    localparam int DEF_CTRL_W = 11;

    typedef logic [1:0] occ_t;

    function automatic occ_t occCount(input logic mainValid, input logic skidValid);
        return occ_t'({1'b0, mainValid}) + occ_t'({1'b0, skidValid});
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream carrying a datapath payload plus a control payload.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);

endinterface

// File: rtl/pipe_stage_skid_entry.sv
// One pipeline entry: a valid flag plus a payload register.
// Clear drops only the valid flag; the payload keeps its last loaded value.
module pipe_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with an optional second (skid) entry.
// With the skid entry enabled, in_ready comes straight from a flop and never sees out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int SKID_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    pipe_stage_skid_if.slave   in_if,
    pipe_stage_skid_if.master  out_if,
    output occ_t               occupancy_o
);

    localparam int PW = DATA_W + CTRL_W;

    logic          mainValid;
    logic          skidValid;
    logic          inReady;
    logic          accept;
    logic          mainFree;
    logic          mainLoad;
    logic          mainClr;
    logic          skidLoad;
    logic          skidClr;
    logic          mainNext;
    logic          skidNext;
    logic [PW-1:0] inPayload;
    logic [PW-1:0] mainD;
    logic [PW-1:0] mainPayload;
    logic [PW-1:0] skidPayload;
    occ_t          occupancy_q;
    occ_t          occupancy_d;

    assign inPayload = {in_if.ctrl, in_if.data};
    assign accept    = in_if.valid && inReady;
    assign mainFree  = !mainValid || out_if.ready;

    // Skid entry drains into main before any new input is taken, which keeps order FIFO.
    always_comb begin
        mainLoad = 1'b0;
        mainClr  = 1'b0;
        skidLoad = 1'b0;
        skidClr  = 1'b0;
        mainD    = inPayload;
        mainNext = mainValid;
        skidNext = skidValid;
        if (flush_i) begin
            mainClr  = 1'b1;
            skidClr  = 1'b1;
            mainNext = 1'b0;
            skidNext = 1'b0;
        end else if (mainFree) begin
            if (skidValid) begin
                mainLoad = 1'b1;
                mainD    = skidPayload;
                skidClr  = 1'b1;
                mainNext = 1'b1;
                skidNext = 1'b0;
            end else if (accept) begin
                mainLoad = 1'b1;
                mainNext = 1'b1;
            end else begin
                mainClr  = 1'b1;
                mainNext = 1'b0;
            end
        end else if (accept) begin
            skidLoad = 1'b1;
            skidNext = 1'b1;
        end
    end

    assign occupancy_d = occCount(mainNext, skidNext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    pipe_entry #(.W(PW)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (mainClr),
        .load_i  (mainLoad),
        .d_i     (mainD),
        .valid_o (mainValid),
        .data_o  (mainPayload)
    );

    generate
        if (SKID_EN != 0) begin : gSkid
            pipe_entry #(.W(PW)) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr_i   (skidClr),
                .load_i  (skidLoad),
                .d_i     (inPayload),
                .valid_o (skidValid),
                .data_o  (skidPayload)
            );
            assign inReady = !skidValid;
        end else begin : gNoSkid
            assign skidValid   = 1'b0;
            assign skidPayload = '0;
            assign inReady     = out_if.ready || !mainValid;
        end
    endgenerate

    assign in_if.ready  = inReady;
    assign out_if.valid = mainValid;
    assign out_if.data  = mainPayload[DATA_W-1:0];
    assign out_if.ctrl  = mainValid ? mainPayload[PW-1:DATA_W] : '0;
    assign occupancy_o  = occupancy_q;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 96, width of the datapath payload (ALU result, branch target, store data).
REQ-002 Parameter CTRL_W, default 11, width of the control payload (rd address, flags, mem/reg enables).
REQ-003 Parameter SKID_EN, default 1; 1 selects a 2-entry skid stage, 0 selects a single-entry stage.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  upstream presents a payload.
REQ-008 in_ready  output  1  stage accepts the payload this cycle.
REQ-009 in_data  input  DATA_W  upstream datapath payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 out_valid  output  1  main entry holds a live payload.
REQ-012 out_ready  input  1  downstream consumes the payload this cycle.
REQ-013 out_data  output  DATA_W  main entry datapath payload.
REQ-014 out_ctrl  output  CTRL_W  main entry control, forced to 0 when out_valid=0.
REQ-015 occupancy  output  2  number of live entries, 0..2.

Function
REQ-016 Accept = in_valid && in_ready; transfer = out_valid && out_ready.
REQ-017 SKID_EN=1: in_ready = !skid_valid, driven from a flop only (no combinational path from out_ready).
REQ-018 SKID_EN=0: in_ready = out_ready || !main_valid; skid entry is absent and occupancy never exceeds 1.
REQ-019 Main free (transfer or !main_valid) and skid_valid: main loads skid next edge, skid becomes empty.
REQ-020 Main free and !skid_valid: main loads input if accepted, else main_valid clears.
REQ-021 Main held (main_valid && !out_ready) and accept: skid loads input; main unchanged.
REQ-022 Main held and no accept: both entries unchanged (stall).
REQ-023 Ordering is strictly FIFO; no payload is duplicated or dropped except by flush.
REQ-024 Latency: payload accepted at edge N appears on out_* after edge N when the stage is empty (1 cycle).
REQ-025 Full (occupancy=2): in_ready=0; a simultaneous transfer moves skid to main, and in_ready returns to 1 after that edge.
REQ-026 Flush has priority over accept, transfer and stall: at the next edge main_valid=0, skid_valid=0, occupancy=0; in_valid in the flush cycle is discarded.
REQ-027 Flush while empty is harmless; flush held for several cycles keeps the stage empty and in_ready=1 (SKID_EN=1).
REQ-028 Data registers load only on accept or skid-to-main move; on flush they keep their value, masked by valid.
REQ-029 occupancy = main_valid + skid_valid, registered alongside them.

Reset
REQ-030 rst_n low asynchronously clears main_valid, skid_valid, out_data, out_ctrl, occupancy to 0; in_ready=1 (SKID_EN=1) during reset.
REQ-031 Reset asserted mid-stall discards all entries; first edge after release behaves as an empty stage.

Structure
REQ-032 Shared package pipe_pkg holds default DATA_W/CTRL_W constants and the occupancy type.
REQ-033 One sub-module pipe_entry (valid flag + payload flop with load and clear) is instantiated for main and, when SKID_EN=1, for skid.

Verification
REQ-034 Empty stage, in_valid=1, in_data=0x...AA, out_ready=1 -> out_valid=1, out_data=0x...AA one cycle later, occupancy=1.
REQ-035 out_ready=0, push A then B -> occupancy=2, in_ready=0; raise out_ready -> A then B out on consecutive cycles, in_ready=1 after A leaves.
REQ-036 Full stage, flush=1 with in_valid=1 payload C -> next cycle out_valid=0, out_ctrl=0, occupancy=0, C never appears.
REQ-037 Continuous streaming 1..100 with random out_ready -> output sequence exactly 1..100, no gaps, no duplicates.
REQ-038 SKID_EN=0, out_ready=0 with main full -> in_ready=0 same cycle; occupancy never exceeds 1.
REQ-039 rst_n low mid-stall with occupancy=2 -> all outputs 0 immediately, no clock edge required.
